// File: rtl/keychain_uart_tx.sv
// 8N1 UART serializer: accepts a MSG_BYTES-wide word via valid/ready and sends it byte 0 first.
// Optional macro KEYCHAIN_TX_CHECKSUM_EN appends an XOR-of-all-bytes checksum byte.
module keychain_uart_tx #(
    parameter int unsigned CLK_FREQ  = 10_000_000,
    parameter int unsigned BAUD_RATE = 115_200,
    parameter int unsigned MSG_BYTES = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [8*MSG_BYTES-1:0] data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic                   busy_out,
    output logic                   tx_wire_out
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BaudW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned ByteW    = (MSG_BYTES > 0) ? $clog2(MSG_BYTES + 1) : 1;
`ifdef KEYCHAIN_TX_CHECKSUM_EN
    localparam int unsigned NumTx    = MSG_BYTES + 1;
`else
    localparam int unsigned NumTx    = MSG_BYTES;
`endif
    localparam int unsigned ShiftW   = 8 * NumTx;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e              state_q, state_d;
    logic [BaudW-1:0]    baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [ByteW-1:0]    byte_q, byte_d;
    logic [ShiftW-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic [ShiftW-1:0]   load_word;
    logic                baud_wrap;

`ifdef KEYCHAIN_TX_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = '0;
        for (int k = 0; k < int'(MSG_BYTES); k++) begin
            csum = csum ^ data_in[8*k +: 8];
        end
    end

    // Checksum sits above the data bytes so it shifts out last.
    assign load_word = {csum, data_in};
`else
    assign load_word = data_in;
`endif

    assign baud_wrap = (baud_q == BaudW'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ready_d = ready_q;

        if (state_q != StIdle) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (valid_in && ready_q) begin
                    state_d = StStart;
                    shift_d = load_word;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            StStart: begin
                if (baud_wrap) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (baud_wrap) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (baud_wrap) begin
                    if (byte_q == ByteW'(NumTx - 1)) begin
                        state_d = StIdle;
                        ready_d = 1'b1;
                        byte_d  = '0;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        state_d = StStart;
                        byte_d  = byte_q + 1'b1;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    assign tx_wire_out = tx_q;
    assign ready_out   = ready_q;
    assign busy_out    = ~ready_q;

endmodule

// File: tb/tb_keychain_uart_tx.sv
// Directed bench for keychain_uart_tx: captures the TX line cycle by cycle and decodes frames.
// Define KEYCHAIN_TX_CHECKSUM_EN to expect the trailing checksum byte.
module tb_keychain_uart_tx;

    localparam int Div = 86;
`ifdef KEYCHAIN_TX_CHECKSUM_EN
    localparam int NTx = 5;
`else
    localparam int NTx = 4;
`endif
    localparam int WordLen = NTx * 10 * Div;
    localparam int CapLen  = 9000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic        busy_out;
    logic        tx_wire_out;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_bad = 0;

    logic cap_tx  [CapLen];
    logic cap_rdy [CapLen];

    keychain_uart_tx dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .busy_out    (busy_out),
        .tx_wire_out (tx_wire_out)
    );

    always #50 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Records n negedge samples; optionally raises valid_in at on_idx and drops it at off_idx.
    task automatic capture(input int n, input int on_idx, input int off_idx, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            if (i == on_idx) begin
                valid_in = 1'b1;
                data_in  = d;
            end
            if (i == off_idx) valid_in = 1'b0;
            cap_tx[i]  = tx_wire_out;
            cap_rdy[i] = ready_out;
            if (busy_out !== ~ready_out) busy_bad++;
            @(negedge clk_in);
        end
    endtask

    // Presents a word for one accept edge; leaves valid_in high when hold is set.
    task automatic start_word(input logic [31:0] d, input logic hold, input string tag);
        data_in  = d;
        valid_in = 1'b1;
        @(negedge clk_in);
        if (!hold) begin
            valid_in = 1'b0;
            data_in  = '0;
        end
        chk({tag, " start tx"}, 32'(tx_wire_out), 32'd0);
        chk({tag, " start ready"}, 32'(ready_out), 32'd0);
        chk({tag, " start busy"}, 32'(busy_out), 32'd1);
    endtask

    task automatic check_word(input int off, input logic [31:0] w, input logic [7:0] cs,
                              input string tag);
        for (int k = 0; k < NTx; k++) begin
            logic [7:0] exp_b;
            logic [7:0] got_b;
            logic       exp_bit;
            int         bad;
            exp_b = (k < 4) ? w[8*k +: 8] : cs;
            got_b = '0;
            bad   = 0;
            for (int b = 0; b < 10; b++) begin
                exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
                for (int c = 0; c < Div; c++) begin
                    if (cap_tx[off + (10*k + b)*Div + c] !== exp_bit) bad++;
                end
                if (b >= 1 && b <= 8) got_b[b-1] = cap_tx[off + (10*k + b)*Div + Div/2];
            end
            chk($sformatf("%s byte%0d value", tag, k), 32'(got_b), 32'(exp_b));
            chk($sformatf("%s byte%0d bad cycles", tag, k), bad, 0);
        end
    endtask

    function automatic int first_ready(input int from, input int to);
        for (int i = from; i < to; i++) begin
            if (cap_rdy[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    function automatic int count_low(input int from, input int to);
        int n = 0;
        for (int i = from; i < to; i++) begin
            if (cap_tx[i] !== 1'b1 || cap_rdy[i] !== 1'b1) n++;
        end
        return n;
    endfunction

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;

        // Reset and idle stability.
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        chk("reset tx", 32'(tx_wire_out), 32'd1);
        chk("reset ready", 32'(ready_out), 32'd1);
        chk("reset busy", 32'(busy_out), 32'd0);
        capture(1000, -1, -1, '0);
        chk("idle 1000 cycles", count_low(0, 1000), 0);

        // Single word, with a 0xFFFFFFFF pulse while busy that must be ignored.
        start_word(32'hA53C0F81, 1'b0, "single");
        capture(WordLen + 60, 1000, 1001, 32'hFFFFFFFF);
        check_word(0, 32'hA53C0F81, 8'h17, "single");
        chk("single ready return", first_ready(0, WordLen + 60), WordLen);
        chk("single no extra frame", count_low(WordLen, WordLen + 60), 0);

        // Back-to-back words with valid_in held high.
        start_word(32'h00000001, 1'b1, "b2b");
        data_in = 32'h80000000;
        capture(2*WordLen + 40, -1, WordLen + 1, '0);
        check_word(0, 32'h00000001, 8'h01, "b2b w0");
        chk("b2b idle cycle tx", 32'(cap_tx[WordLen]), 32'd1);
        chk("b2b idle cycle ready", 32'(cap_rdy[WordLen]), 32'd1);
        chk("b2b second accept", 32'(cap_rdy[WordLen + 1]), 32'd0);
        check_word(WordLen + 1, 32'h80000000, 8'h80, "b2b w1");
        chk("b2b ready return", first_ready(WordLen + 1, 2*WordLen + 40), 2*WordLen + 1);
        chk("b2b no third word", count_low(2*WordLen + 1, 2*WordLen + 40), 0);

        // Reset during bit 3 of byte 1 (all-zero word keeps the line low there).
        start_word(32'h00000000, 1'b0, "midrst");
        repeat (10*Div + 4*Div + 40) @(negedge clk_in);
        chk("midrst pre tx", 32'(tx_wire_out), 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("midrst tx", 32'(tx_wire_out), 32'd1);
        chk("midrst ready", 32'(ready_out), 32'd1);
        chk("midrst busy", 32'(busy_out), 32'd0);
        capture(300, -1, -1, '0);
        chk("midrst no resume", count_low(0, 300), 0);

        start_word(32'h12345678, 1'b0, "post");
        capture(WordLen + 20, -1, -1, '0);
        check_word(0, 32'h12345678, 8'h08, "post");
        chk("post ready return", first_ready(0, WordLen + 20), WordLen);

        chk("busy equals not ready", busy_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
